// File: rtl/keypad_event_scanner_pkg.sv
// Shared types, event word layout and width helper for the keypad event scanner.
package keypad_event_scanner_pkg;

   // Scan sequencer states: idle only between reset release and the first row drive.
   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StEval
   } scan_state_e;

   // Event word layout: {code, press, repeat}.
   localparam int unsigned EvRepeatBit = 0;
   localparam int unsigned EvPressBit  = 1;
   localparam int unsigned EvCodeLsb   = 2;

   // Index width for n items, never below one bit.
   function automatic int unsigned key_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/keypad_event_scanner_sync_fifo.sv
// Show-ahead synchronous FIFO; head is read combinationally from storage.
module keypad_event_scanner_sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic             wr_en, rd_en;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   // A pop frees the slot in the same cycle, so a full FIFO still accepts push+pop.
   assign wr_en   = push_i & (~full_o | pop_i);
   assign rd_en   = pop_i & ~empty_o;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   // Storage and pointer update.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
            wptr_q                <= wptr_q + (AW+1)'(1);
         end
         if (rd_en) rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/keypad_event_scanner.sv
// Matrix keypad scanner: row scan, per-key debounce, auto-repeat, event FIFO.
module keypad_event_scanner
   import keypad_event_scanner_pkg::*;
#(
   parameter int unsigned ROWS           = 4,
   parameter int unsigned COLS           = 4,
   parameter int unsigned ROW_DWELL_CYC  = 50000,
   parameter int unsigned DEBOUNCE_SCANS = 20,
   parameter int unsigned REPEAT_EN      = 1,
   parameter int unsigned REPEAT_DELAY   = 500,
   parameter int unsigned REPEAT_PERIOD  = 100,
   parameter int unsigned FIFO_DEPTH     = 8,
   localparam int unsigned NKEYS         = ROWS * COLS,
   localparam int unsigned KW            = key_width(NKEYS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [COLS-1:0]  col_i,
   output logic [ROWS-1:0]  row_o,
   output logic             ev_valid_o,
   input  logic             ev_ready_i,
   output logic [KW-1:0]    ev_code_o,
   output logic             ev_press_o,
   output logic             ev_repeat_o,
   output logic [NKEYS-1:0] key_state_o,
   output logic             overflow_o,
   input  logic             clr_overflow_i
);

   localparam int unsigned RW  = key_width(ROWS);
   localparam int unsigned CW  = key_width(COLS);
   localparam int unsigned DWW = key_width(ROW_DWELL_CYC);
   localparam int unsigned DBW = key_width(DEBOUNCE_SCANS + 1);
   localparam int unsigned EW  = KW + 2;

   localparam logic [DWW-1:0] SampleAt  = DWW'(ROW_DWELL_CYC - COLS - 1);
   localparam logic [DWW-1:0] EvalStart = DWW'(ROW_DWELL_CYC - COLS);
   localparam logic [DWW-1:0] DwellLast = DWW'(ROW_DWELL_CYC - 1);
   localparam logic [RW-1:0]  RowLast   = RW'(ROWS - 1);
   localparam logic [DBW-1:0] DebLast   = DBW'(DEBOUNCE_SCANS - 1);

   scan_state_e      state_q, state_d;
   logic [RW-1:0]    r_q, r_d;
   logic [DWW-1:0]   dwell_q, dwell_d;
   logic [COLS-1:0]  sync1_q, sync2_q, sample_q, sample_d;
   logic [NKEYS-1:0] key_state_q, key_state_d;
   logic [DBW-1:0]   cnt_q [NKEYS];
   logic [DBW-1:0]   cnt_d [NKEYS];
   logic             overflow_q, overflow_d;

   logic [CW-1:0]    col_idx;
   logic [KW-1:0]    key_idx;
   logic             raw;
   logic             deb_push, deb_press, frame_end;
   logic [KW-1:0]    deb_code;
   logic             rep_push;
   logic [KW-1:0]    rep_key;

   logic             push, pop, fifo_full, fifo_empty;
   logic [EW-1:0]    ev_wdata, ev_rdata;

   // Column synchroniser, scan state, debounced levels and overflow flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         r_q         <= '0;
         dwell_q     <= '0;
         sync1_q     <= '1;
         sync2_q     <= '1;
         sample_q    <= '1;
         key_state_q <= '0;
         overflow_q  <= 1'b0;
         for (int i = 0; i < int'(NKEYS); i++) cnt_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         dwell_q     <= dwell_d;
         sync1_q     <= col_i;
         sync2_q     <= sync1_q;
         sample_q    <= sample_d;
         key_state_q <= key_state_d;
         overflow_q  <= overflow_d;
         cnt_q       <= cnt_d;
      end
   end

   // Scan sequencing plus one debounce evaluation per EVAL cycle.
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      dwell_d     = dwell_q;
      sample_d    = sample_q;
      key_state_d = key_state_q;
      cnt_d       = cnt_q;
      col_idx     = '0;
      key_idx     = '0;
      raw         = 1'b0;
      deb_push    = 1'b0;
      deb_press   = 1'b0;
      deb_code    = '0;
      frame_end   = 1'b0;
      unique case (state_q)
         StIdle: begin
            state_d = StDrive;
            r_d     = '0;
            dwell_d = '0;
         end
         StDrive: begin
            dwell_d = dwell_q + DWW'(1);
            if (dwell_q == SampleAt) begin
               sample_d = sync2_q;
               state_d  = StEval;
            end
         end
         StEval: begin
            col_idx = CW'(dwell_q - EvalStart);
            key_idx = KW'(r_q) * KW'(COLS) + KW'(col_idx);
            raw     = ~sample_q[col_idx];
            if (raw == key_state_q[key_idx]) begin
               cnt_d[key_idx] = '0;
            end else if (cnt_q[key_idx] == DebLast) begin
               key_state_d[key_idx] = raw;
               cnt_d[key_idx]       = '0;
               deb_push             = 1'b1;
               deb_press            = raw;
               deb_code             = key_idx;
            end else begin
               cnt_d[key_idx] = cnt_q[key_idx] + DBW'(1);
            end
            if (dwell_q == DwellLast) begin
               state_d = StDrive;
               dwell_d = '0;
               if (r_q == RowLast) begin
                  r_d       = '0;
                  frame_end = 1'b1;
               end else begin
                  r_d = r_q + RW'(1);
               end
            end else begin
               dwell_d = dwell_q + DWW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   if (REPEAT_EN != 0) begin : g_repeat
      localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
      localparam int unsigned RPW = key_width(RepMax + 2);
      localparam logic [RPW-1:0] RepDelay  = RPW'(REPEAT_DELAY);
      localparam logic [RPW-1:0] RepPeriod = RPW'(REPEAT_PERIOD);

      logic [KW-1:0]  rep_key_q, rep_key_d;
      logic [RPW-1:0] rep_cnt_q, rep_cnt_d, rep_thr, rep_inc;
      logic           rep_armed_q, rep_armed_d, rep_first_q, rep_first_d;

      // Repeat tracking registers.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            rep_key_q   <= '0;
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            rep_first_q <= 1'b0;
         end else begin
            rep_key_q   <= rep_key_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
            rep_first_q <= rep_first_d;
         end
      end

      // Frame counting for the most recent press; a debounce push blocks the repeat push,
      // and the counter parks at threshold so the repeat fires on the next frame.
      always_comb begin
         rep_key_d   = rep_key_q;
         rep_cnt_d   = rep_cnt_q;
         rep_armed_d = rep_armed_q;
         rep_first_d = rep_first_q;
         rep_push    = 1'b0;
         rep_thr     = rep_first_q ? RepDelay : RepPeriod;
         rep_inc     = rep_cnt_q + RPW'(1);
         if (deb_push && deb_press) begin
            rep_key_d   = deb_code;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
            rep_first_d = 1'b1;
         end else if (deb_push && (deb_code == rep_key_q)) begin
            rep_armed_d = 1'b0;
         end else if (frame_end && rep_armed_q && key_state_q[rep_key_q]) begin
            if (rep_inc >= rep_thr) begin
               if (deb_push) begin
                  rep_cnt_d = rep_thr;
               end else begin
                  rep_push    = 1'b1;
                  rep_cnt_d   = '0;
                  rep_first_d = 1'b0;
               end
            end else begin
               rep_cnt_d = rep_inc;
            end
         end
      end

      assign rep_key = rep_key_q;
   end else begin : g_no_repeat
      assign rep_push = 1'b0;
      assign rep_key  = '0;
   end

   assign push     = deb_push | rep_push;
   assign ev_wdata = deb_push ? {deb_code, deb_press, 1'b0} : {rep_key, 1'b1, 1'b1};
   assign pop      = ~fifo_empty & ev_ready_i;

   // Sticky overflow; a new drop outranks a clear in the same cycle.
   always_comb begin
      overflow_d = overflow_q;
      if (clr_overflow_i) overflow_d = 1'b0;
      if (push && fifo_full && !pop) overflow_d = 1'b1;
   end

   keypad_event_scanner_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .wdata_i (ev_wdata),
      .pop_i   (pop),
      .rdata_o (ev_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Active-low one-hot row drive; all rows released until the first scan step.
   always_comb begin
      row_o = '1;
      if (state_q != StIdle) row_o = ~(ROWS'(1) << r_q);
   end

   assign ev_valid_o  = ~fifo_empty;
   assign ev_code_o   = ev_rdata[EvCodeLsb +: KW];
   assign ev_press_o  = ev_rdata[EvPressBit];
   assign ev_repeat_o = ev_rdata[EvRepeatBit];
   assign key_state_o = key_state_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Directed bench for keypad_event_scanner with a behavioural 4x4 key matrix.
module tb_keypad_event_scanner;

   localparam int Frame = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  col;
   logic [3:0]  row;
   logic        ev_valid, ev_ready, ev_press, ev_repeat, overflow, clr_overflow;
   logic [3:0]  ev_code;
   logic [15:0] key_state;
   logic [15:0] pressed;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   keypad_event_scanner #(
      .ROWS           (4),
      .COLS           (4),
      .ROW_DWELL_CYC  (8),
      .DEBOUNCE_SCANS (3),
      .REPEAT_EN      (1),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (4),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .col_i          (col),
      .row_o          (row),
      .ev_valid_o     (ev_valid),
      .ev_ready_i     (ev_ready),
      .ev_code_o      (ev_code),
      .ev_press_o     (ev_press),
      .ev_repeat_o    (ev_repeat),
      .key_state_o    (key_state),
      .overflow_o     (overflow),
      .clr_overflow_i (clr_overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Key matrix: a held key pulls its column low while its row is driven low.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      pressed      = '0;
      ev_ready     = 1'b0;
      clr_overflow = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic get_event(input int bound, output bit got, output logic [3:0] code,
                            output logic pr, output logic rp, output int t);
      got  = 1'b0;
      code = '0;
      pr   = 1'b0;
      rp   = 1'b0;
      t    = 0;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge clk);
         if (ev_valid) begin
            got  = 1'b1;
            code = ev_code;
            pr   = ev_press;
            rp   = ev_repeat;
            t    = cyc;
         end
      end
   endtask

   task automatic quiet_for(input int cycles, input string name);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (ev_valid) seen++;
      end
      check(name, seen, 0);
   endtask

   typedef struct {
      int         r;
      int         c;
      logic [3:0] code;
   } vec_t;

   vec_t       vecs [4];
   logic [3:0] row_seq [4];

   initial begin
      bit         got;
      logic [3:0] code;
      logic       pr, rp;
      int         t0, t1, t2, t3;

      vecs[0] = '{2, 1, 4'd9};
      vecs[1] = '{0, 0, 4'd0};
      vecs[2] = '{3, 3, 4'd15};
      vecs[3] = '{1, 2, 4'd6};
      row_seq[0] = 4'hE;
      row_seq[1] = 4'hD;
      row_seq[2] = 4'hB;
      row_seq[3] = 4'h7;

      // Reset state and row sequence.
      rst          = 1'b1;
      pressed      = '0;
      ev_ready     = 1'b0;
      clr_overflow = 1'b0;
      repeat (5) @(negedge clk);
      check("reset row", row, 4'hF);
      check("reset ev_valid", ev_valid, 0);
      check("reset key_state", key_state, 0);
      check("reset overflow", overflow, 0);
      check("reset ev_fields", {ev_code, ev_press, ev_repeat}, 0);
      rst = 1'b0;
      for (int i = 0; i < 2 * Frame; i++) begin
         @(negedge clk);
         check($sformatf("row step %0d", i), row, row_seq[(i / 8) % 4]);
      end

      // Single clean key press/release per table entry.
      foreach (vecs[v]) begin
         do_reset();
         ev_ready = 1'b1;
         pressed[vecs[v].r*4 + vecs[v].c] = 1'b1;
         get_event(4 * Frame + 4, got, code, pr, rp, t0);
         check($sformatf("vec%0d press seen", v), got, 1);
         check($sformatf("vec%0d press code", v), code, vecs[v].code);
         check($sformatf("vec%0d press flags", v), {pr, rp}, 2'b10);
         check($sformatf("vec%0d key_state held", v), key_state,
               32'(16'h1 << vecs[v].code));
         pressed = '0;
         get_event(4 * Frame + 4, got, code, pr, rp, t0);
         check($sformatf("vec%0d release seen", v), got, 1);
         check($sformatf("vec%0d release code", v), code, vecs[v].code);
         check($sformatf("vec%0d release flags", v), {pr, rp}, 2'b00);
         check($sformatf("vec%0d key_state clear", v), key_state, 0);
      end

      // Bounce: one-frame glitches on key 5 never reach the debounce count.
      do_reset();
      ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pressed[5] = 1'b1;
         quiet_for(Frame, $sformatf("bounce high %0d events", i));
         pressed[5] = 1'b0;
         quiet_for(2 * Frame, $sformatf("bounce low %0d events", i));
      end
      check("bounce key_state", key_state, 0);

      // Two keys in the same frame report in scan order.
      do_reset();
      ev_ready    = 1'b1;
      pressed[0]  = 1'b1;
      pressed[15] = 1'b1;
      get_event(4 * Frame + 4, got, code, pr, rp, t0);
      check("dual first", {got, code, pr, rp}, {1'b1, 4'd0, 1'b1, 1'b0});
      get_event(2 * Frame, got, code, pr, rp, t0);
      check("dual second", {got, code, pr, rp}, {1'b1, 4'd15, 1'b1, 1'b0});
      check("dual key_state", key_state, 16'h8001);

      // Auto-repeat on key 3: first after 10 frame ends, then every 4.
      do_reset();
      ev_ready   = 1'b1;
      pressed[3] = 1'b1;
      get_event(4 * Frame + 4, got, code, pr, rp, t0);
      check("rep press", {got, code, pr, rp}, {1'b1, 4'd3, 1'b1, 1'b0});
      get_event(12 * Frame, got, code, pr, rp, t1);
      check("rep first", {got, code, pr, rp}, {1'b1, 4'd3, 1'b1, 1'b1});
      check("rep first delay", t1 - t0, 24 + 9 * Frame);
      get_event(6 * Frame, got, code, pr, rp, t2);
      check("rep second", {got, code, pr, rp}, {1'b1, 4'd3, 1'b1, 1'b1});
      check("rep second period", t2 - t1, 4 * Frame);
      get_event(6 * Frame, got, code, pr, rp, t3);
      check("rep third", {got, code, pr, rp}, {1'b1, 4'd3, 1'b1, 1'b1});
      check("rep third period", t3 - t2, 4 * Frame);
      pressed[3] = 1'b0;
      get_event(5 * Frame, got, code, pr, rp, t0);
      check("rep release", {got, code, pr, rp}, {1'b1, 4'd3, 1'b0, 1'b0});
      quiet_for(15 * Frame, "rep after release events");

      // Overflow: six presses into a four-entry FIFO with the consumer stalled.
      do_reset();
      pressed[5:0] = 6'h3F;
      repeat (5 * Frame) @(negedge clk);
      check("ovf valid", ev_valid, 1);
      check("ovf flag", overflow, 1);
      check("ovf key_state", key_state, 16'h003F);
      check("ovf head stable", {ev_code, ev_press, ev_repeat}, {4'd0, 1'b1, 1'b0});
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain %0d valid", i), ev_valid, 1);
         check($sformatf("drain %0d event", i), {ev_code, ev_press, ev_repeat},
               {4'(i), 1'b1, 1'b0});
         ev_ready = 1'b1;
         @(negedge clk);
         ev_ready = 1'b0;
      end
      check("drain empty", ev_valid, 0);
      check("ovf sticky", overflow, 1);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      check("ovf cleared", overflow, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
